// File: rtl/traffic_pkg.sv
// Shared definitions for the road sensor conditioning path: road indices,
// siren qualifier states, parameter defaults and the arbiter priority helper.
package traffic_pkg;

    localparam int ROAD_S    = 0;
    localparam int ROAD_W    = 1;
    localparam int ROAD_N    = 2;
    localparam int ROAD_E    = 3;
    localparam int NUM_ROADS = 4;

    localparam int CNT_W_DEF      = 6;
    localparam int JAM_ON_DEF     = 16;
    localparam int JAM_OFF_DEF    = 12;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int EMG_HOLD_DEF   = 20;

    typedef enum logic [1:0] {
        SIREN_IDLE,
        SIREN_QUAL,
        SIREN_ACTIVE,
        SIREN_HOLD
    } siren_state_e;

    // Isolates the lowest set bit, so South wins any tie.
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

endpackage

// File: rtl/road_sensor_conditioner_lane_monitor.sv
// One road: detector synchronizers, arrive/depart edge detection, saturating
// occupancy counter with Jam hysteresis, and the siren qualify/hold machine.
module lane_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int JAM_ON     = JAM_ON_DEF,
    parameter int JAM_OFF    = JAM_OFF_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int EMG_HOLD   = EMG_HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive,
    input  logic depart,
    input  logic siren,
    output logic candidate,
    output logic jam,
    output logic empty
);

    localparam int RUN_MAX = (EMG_HOLD > DEB_CYCLES) ? EMG_HOLD : DEB_CYCLES;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] JAM_ON_C  = CNT_W'(JAM_ON);
    localparam logic [CNT_W-1:0] JAM_OFF_C = CNT_W'(JAM_OFF);
    localparam logic [RUN_W-1:0] DEB_LAST  = RUN_W'(DEB_CYCLES - 1);
    localparam logic [RUN_W-1:0] HOLD_LAST = RUN_W'(EMG_HOLD - 1);

    logic [1:0]       arr_sync, dep_sync, sir_sync;
    logic             arr_prev, dep_prev;
    logic             arr_rise, dep_rise, sir_now;
    logic [CNT_W-1:0] count, count_next;
    siren_state_e     state, state_next;
    logic [RUN_W-1:0] run_cnt, run_next;

    // NOTE: non-blocking assignments make each stage capture the previous
    // stage's old value; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_sync <= '0;
            dep_sync <= '0;
            sir_sync <= '0;
            arr_prev <= 1'b0;
            dep_prev <= 1'b0;
        end else begin
            arr_sync <= {arr_sync[0], arrive};
            dep_sync <= {dep_sync[0], depart};
            sir_sync <= {sir_sync[0], siren};
            arr_prev <= arr_sync[1];
            dep_prev <= dep_sync[1];
        end
    end

    assign arr_rise = arr_sync[1] & ~arr_prev;
    assign dep_rise = dep_sync[1] & ~dep_prev;
    assign sir_now  = sir_sync[1];

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_next = count;
        if (arr_rise && !dep_rise && count != CNT_MAX) begin
            count_next = count + CNT_W'(1);
        end else if (dep_rise && !arr_rise && count != '0) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Jam looks at the value being loaded so it flips on the same edge as count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            jam   <= 1'b0;
        end else begin
            count <= count_next;
            if (count_next >= JAM_ON_C) begin
                jam <= 1'b1;
            end else if (count_next <= JAM_OFF_C) begin
                jam <= 1'b0;
            end
        end
    end

    assign empty = (count == '0);

    // run_cnt counts consecutive highs in QUAL and consecutive lows in HOLD.
    always_comb begin
        state_next = state;
        run_next   = run_cnt;
        unique case (state)
            SIREN_IDLE: begin
                if (sir_now) begin
                    if (DEB_LAST == '0) begin
                        state_next = SIREN_ACTIVE;
                    end else begin
                        state_next = SIREN_QUAL;
                        run_next   = RUN_W'(1);
                    end
                end
            end
            SIREN_QUAL: begin
                if (!sir_now) begin
                    state_next = SIREN_IDLE;
                    run_next   = '0;
                end else if (run_cnt == DEB_LAST) begin
                    state_next = SIREN_ACTIVE;
                    run_next   = '0;
                end else begin
                    run_next = run_cnt + RUN_W'(1);
                end
            end
            SIREN_ACTIVE: begin
                if (!sir_now) begin
                    if (HOLD_LAST == '0) begin
                        state_next = SIREN_IDLE;
                    end else begin
                        state_next = SIREN_HOLD;
                        run_next   = RUN_W'(1);
                    end
                end
            end
            SIREN_HOLD: begin
                if (sir_now) begin
                    state_next = SIREN_ACTIVE;
                    run_next   = '0;
                end else if (run_cnt == HOLD_LAST) begin
                    state_next = SIREN_IDLE;
                    run_next   = '0;
                end else begin
                    run_next = run_cnt + RUN_W'(1);
                end
            end
            default: begin
                state_next = SIREN_IDLE;
                run_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SIREN_IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_next;
        end
    end

    assign candidate = (state == SIREN_ACTIVE) || (state == SIREN_HOLD);

endmodule

// File: rtl/road_sensor_conditioner.sv
// Conditions raw per-road detector levels into Empty/Jam flags and a single
// non-preemptive Emergency grant for the traffic light controller.
module road_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int JAM_ON     = JAM_ON_DEF,
    parameter int JAM_OFF    = JAM_OFF_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int EMG_HOLD   = EMG_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Arrive,
    input  logic [3:0] Depart,
    input  logic [3:0] Siren,
    output logic [3:0] Emergency,
    output logic [3:0] Jam,
    output logic [3:0] Empty
);

    logic [3:0] candidate;
    logic [3:0] emergency_next;

    for (genvar i = 0; i < NUM_ROADS; i++) begin : g_lane
        lane_monitor #(
            .CNT_W      (CNT_W),
            .JAM_ON     (JAM_ON),
            .JAM_OFF    (JAM_OFF),
            .DEB_CYCLES (DEB_CYCLES),
            .EMG_HOLD   (EMG_HOLD)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .arrive    (Arrive[i]),
            .depart    (Depart[i]),
            .siren     (Siren[i]),
            .candidate (candidate[i]),
            .jam       (Jam[i]),
            .empty     (Empty[i])
        );
    end

    // The current holder keeps the grant while still a candidate; otherwise
    // the lowest-index candidate takes over on this edge.
    always_comb begin
        emergency_next = lowest_one(candidate);
        if ((Emergency & candidate) != 4'b0000) begin
            emergency_next = Emergency;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Emergency <= 4'b0000;
        end else begin
            Emergency <= emergency_next;
        end
    end

endmodule
